pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that drives the pipeline PC register and the instruction-memory request port.
- Produces `next_pc` and `pc_stall` for the PC register and issues one outstanding fetch at a time.
- Kills stale responses on branch/jump redirect and buffers one fetched instruction toward the IF/ID stage under pipeline back-pressure.

Parameters:
- PC_INC, 4, byte increment for sequential fetch.
- CNT_W, 32, width of performance counters (used only with FETCH_PERF_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- current_pc  in  32  PC register output
- next_pc  out  32  PC register next-value input
- pc_stall  out  1  PC register hold (1 = hold)
- redirect_valid  in  1  taken branch/jump/trap from EX
- redirect_pc  in  32  redirect target
- pipe_stall  in  1  IF/ID cannot accept (load-use hazard etc.)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; held by memory until rready
- imem_rready  out  1  response accepted
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  buffered instruction valid
- if_pc  out  32  PC of buffered instruction
- if_inst  out  32  buffered instruction

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `rst` is asynchronous, active-high.
  - Reset values: state=IDLE, kill=0, req_pc=0, if_valid=0, if_pc=0, if_inst=0.
  - Combinational outputs therefore reset to imem_req=0, imem_rready=0, pc_stall=1.
- States: IDLE, REQ, WAIT. IDLE→REQ unconditionally one cycle after reset release.
- next_pc:
  - redirect_pc when redirect_valid=1.
  - Otherwise current_pc+PC_INC, modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- pc_stall=0 only when redirect_valid=1, or when state=REQ and imem_gnt=1. Otherwise 1.
- REQ:
  - imem_req=1, imem_addr=current_pc (combinational).
  - Memory samples the address only on the gnt cycle. An ungranted request may retarget after a redirect.
  - On gnt: req_pc<=current_pc, go to WAIT.
  - If redirect_valid coincides with gnt: kill<=1.
- WAIT:
  - Any redirect_valid sets kill<=1.
  - imem_rready = kill | !if_valid | !pipe_stall | redirect_valid.
  - On rvalid&rready: go to REQ.
  - If neither kill nor redirect_valid is set that cycle: if_valid<=1, if_pc<=req_pc, if_inst<=imem_rdata.
  - If kill is set: drop the data and clear kill.
- Output buffer:
  - Consumed when if_valid & !pipe_stall; if_valid<=0 unless reloaded in the same cycle.
  - redirect_valid clears if_valid next cycle; this has priority over a consume.
- Redirect in IDLE/REQ without gnt: PC takes redirect_pc, no kill, the request retargets.
- Latency: gnt at cycle N, earliest rvalid at N+1, if_valid at N+2. Best throughput is one instruction per 2 cycles.
- Reset mid-fetch: all state clears immediately. The memory shares `rst` and abandons its transaction.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs `perf_fetch_cnt` (CNT_W) and `perf_kill_cnt` (CNT_W).
  - `perf_fetch_cnt` increments on each buffer load.
  - `perf_kill_cnt` increments on each dropped response.
  - Both reset to 0 and wrap at 2^CNT_W.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_e enum (IDLE, REQ, WAIT);
  - the PC_RESET_VAL=32'h0 constant shared with the PC register;
  - the INST_NOP=32'h00000013 constant for downstream bubble insertion.
- One sub-module, fetch_buf: a one-entry if_valid/if_pc/if_inst holding register with load/consume/flush inputs.
- The FSM, kill flag and next_pc logic remain in pc_fetch_ctrl.

Test Plan:
- Reset release, gnt same cycle, rvalid next cycle, no stalls → fetches 0x0, 0x4, 0x8; if_pc matches every 2 cycles; pc_stall low only on gnt cycles.
- Response for 0x8 in buffer, pipe_stall=1 for 3 cycles, next rvalid pending → imem_rready=0, if_inst held; stall drops, then 0xC loads.
- redirect_valid with redirect_pc=0x100 in WAIT (addr 0x10) → rvalid data for 0x10 dropped, never visible on if_*; next imem_addr=0x100.
- redirect_valid coincident with gnt at 0x20 → kill set; response dropped; next request 0x40 (redirect_pc).
- current_pc=0xFFFFFFFC, granted → next_pc=0x0, next imem_addr=0x0.
- Assert rst during WAIT with if_valid=1 → same-cycle if_valid=0, imem_req=0; after release fetch restarts at 0x0 (with FETCH_PERF_EN, counters read 0).

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch slice.
//   fetch_state_e : fetch sequencer states (IDLE, REQ, WAIT)
//   PC_RESET_VAL  : PC value after reset, shared with the PC register
//   INST_NOP      : canonical NOP (addi x0,x0,0) for downstream bubble insertion
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// One-entry holding register between fetch and the IF/ID stage.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load             : capture load_pc/load_inst, mark entry valid
//   consume          : downstream took the entry this cycle
//   flush            : discard the entry (redirect); beats consume
//   load_pc/load_inst: incoming PC and instruction
//   valid/pc/inst    : buffered entry
// Priority: flush > load > consume. A load in the same cycle as a consume
// replaces the entry, so back-to-back delivery needs no bubble.
// -----------------------------------------------------------------------------
module fetch_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        consume,
   input  logic        flush,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] inst
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= 32'h0;
         inst  <= 32'h0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         inst  <= load_inst;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch sequencer: drives the PC register (next_pc/pc_stall), issues one
// outstanding instruction-memory request at a time, kills responses made
// stale by a redirect, and buffers one instruction toward IF/ID.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   current_pc -> next_pc,pc_stall: PC register interface
//   redirect_valid, redirect_pc  : taken branch/jump/trap from EX
//   pipe_stall                   : IF/ID cannot accept
//   imem_req/addr/gnt            : request channel (addr sampled on gnt)
//   imem_rvalid/rready/rdata     : response channel (rvalid held until rready)
//   if_valid/if_pc/if_inst       : buffered instruction
// Optional feature, macro FETCH_PERF_EN: adds CNT_W parameter and the
//   perf_fetch_cnt (buffer loads) / perf_kill_cnt (dropped responses) outputs.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned PC_INC = 4
`ifdef FETCH_PERF_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] current_pc,
   output logic [31:0] next_pc,
   output logic        pc_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        pipe_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   output logic        imem_rready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
`ifdef FETCH_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_fetch_cnt,
   output logic [CNT_W-1:0] perf_kill_cnt
`endif
);

   fetch_state_e state_reg;
   logic         kill_reg;
   logic [31:0]  req_pc_reg;

   logic gnt_fire;
   logic rsp_fire;
   logic buf_load;
   logic buf_consume;
   logic rsp_drop;

   assign imem_req  = (state_reg == REQ);
   // The address follows the PC every cycle so an ungranted request
   // retargets automatically when a redirect moves the PC.
   assign imem_addr = current_pc;

   assign next_pc  = redirect_valid ? redirect_pc : current_pc + 32'(PC_INC);
   assign pc_stall = !(redirect_valid || (imem_req && imem_gnt));

   // Accept the response if it will be dropped anyway, or the buffer is
   // empty, or the buffered entry leaves this cycle.
   assign imem_rready = (state_reg == WAIT) &&
                        (kill_reg || !if_valid || !pipe_stall || redirect_valid);

   assign gnt_fire    = imem_req && imem_gnt;
   assign rsp_fire    = imem_rready && imem_rvalid;
   assign buf_load    = rsp_fire && !kill_reg && !redirect_valid;
   assign rsp_drop    = rsp_fire && (kill_reg || redirect_valid);
   assign buf_consume = if_valid && !pipe_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         kill_reg   <= 1'b0;
         req_pc_reg <= PC_RESET_VAL;
      end else begin
         case (state_reg)
            IDLE: state_reg <= REQ;
            REQ: begin
               if (gnt_fire) begin
                  req_pc_reg <= current_pc;
                  state_reg  <= WAIT;
                  // Redirect on the grant cycle: the in-flight fetch is for
                  // the old path, so mark it stale.
                  kill_reg   <= redirect_valid;
               end
            end
            WAIT: begin
               if (rsp_fire) begin
                  // The only outstanding response is gone; nothing left to kill.
                  state_reg <= REQ;
                  kill_reg  <= 1'b0;
               end else if (redirect_valid) begin
                  kill_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   fetch_buf u_fetch_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .consume   (buf_consume),
      .flush     (redirect_valid),
      .load_pc   (req_pc_reg),
      .load_inst (imem_rdata),
      .valid     (if_valid),
      .pc        (if_pc),
      .inst      (if_inst)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (buf_load) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
         if (rsp_drop) perf_kill_cnt  <= perf_kill_cnt + 1'b1;
      end
   end
`else
   // Drops are only observed by the performance counters.
   logic unused_drop;
   assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Randomized bench: a PC register and a one-outstanding memory with random
// grant and response latency surround the DUT. A transaction-level reference
// (outstanding fetch + stale flag, one-entry delivery buffer) predicts every
// output each cycle. Checks happen #1 after the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] current_pc;
   logic [31:0] next_pc;
   logic        pc_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        pipe_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic        imem_rready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_kill_cnt;
`endif

   pc_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .current_pc     (current_pc),
      .next_pc        (next_pc),
      .pc_stall       (pc_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pipe_stall     (pipe_stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rready    (imem_rready),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_kill_cnt  (perf_kill_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
   endfunction

   // Reference model
   bit          m_idle, m_out, m_kill, m_bv;
   logic [31:0] m_addr, m_bpc, m_binst;
   int unsigned m_loads, m_drops;
   // Memory environment
   bit          mem_busy;
   int          mem_delay;
   logic [31:0] mem_addr;
   // Per-cycle scratch
   bit          exp_req, exp_stall, exp_rready, gnt_ev, hs;
   logic [31:0] exp_next;
   bit          pc_upd;
   logic [31:0] pc_val;
   bit          want_reset, reset_done;

   task automatic reset_model();
      m_idle = 1; m_out = 0; m_kill = 0; m_bv = 0;
      m_addr = 0; m_bpc = 0; m_binst = 0;
      m_loads = 0; m_drops = 0;
      mem_busy = 0; mem_delay = 0; mem_addr = 0;
      current_pc = 32'h0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      check_eq({tag, "_imem_req"}, 32'(imem_req), 32'd0);
      check_eq({tag, "_rready"},   32'(imem_rready), 32'd0);
      check_eq({tag, "_pc_stall"}, 32'(pc_stall), 32'd1);
      check_eq({tag, "_if_pc"},    if_pc, 32'h0);
      check_eq({tag, "_if_inst"},  if_inst, 32'h0);
   endtask

   initial begin
      redirect_valid = 0; redirect_pc = 0; pipe_stall = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      want_reset = 0; reset_done = 0;
      reset_model();

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 0;

      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (cyc == 600) want_reset = 1;

         // Asynchronous reset while a fetch is in flight and the buffer is full.
         if (want_reset && m_out && m_bv) begin
            redirect_valid = 0;
            rst = 1;
            #1;
            check_reset_outputs("midrst");
            reset_model();
            @(negedge clk);
            check_eq("midrst_hold_req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_EN
            check_eq("midrst_perf_fetch", perf_fetch_cnt, 32'd0);
            check_eq("midrst_perf_kill",  perf_kill_cnt,  32'd0);
`endif
            rst = 0;
            want_reset = 0;
            reset_done = 1;
            $display("reset mid-fetch at cycle %0d", cyc);
         end

         // Drive stimulus
         pipe_stall     = ($urandom_range(0, 99) < 30);
         redirect_valid = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFFC;
         else                           redirect_pc = 32'($urandom_range(0, 255)) << 2;
         imem_gnt    = ($urandom_range(0, 99) < 70);
         imem_rvalid = mem_busy && (mem_delay == 0);
         imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
         #1;

         // Expected values from the transaction-level model
         exp_req    = !m_idle && !m_out;
         exp_next   = redirect_valid ? redirect_pc : current_pc + 32'd4;
         exp_stall  = !(redirect_valid || (exp_req && imem_gnt));
         exp_rready = m_out && (m_kill || !m_bv || !pipe_stall || redirect_valid);

         check_eq("imem_req", 32'(imem_req), 32'(exp_req));
         if (exp_req) check_eq("imem_addr", imem_addr, current_pc);
         check_eq("next_pc", next_pc, exp_next);
         check_eq("pc_stall", 32'(pc_stall), 32'(exp_stall));
         check_eq("imem_rready", 32'(imem_rready), 32'(exp_rready));
         check_eq("if_valid", 32'(if_valid), 32'(m_bv));
         if (m_bv) begin
            check_eq("if_pc", if_pc, m_bpc);
            check_eq("if_inst", if_inst, m_binst);
         end
`ifdef FETCH_PERF_EN
         check_eq("perf_fetch", perf_fetch_cnt, m_loads);
         check_eq("perf_kill",  perf_kill_cnt,  m_drops);
`endif

         // Advance the model across the coming rising edge
         gnt_ev = exp_req && imem_gnt;
         hs     = m_out && imem_rvalid && exp_rready;

         if (redirect_valid) m_bv = 0;
         else if (hs && !m_kill) begin
            m_bv = 1; m_bpc = m_addr; m_binst = mem_word(m_addr); m_loads++;
            $display("load pc=%h inst=%h", m_addr, mem_word(m_addr));
         end else if (m_bv && !pipe_stall) m_bv = 0;

         if (hs && (m_kill || redirect_valid)) begin
            m_drops++;
            $display("drop pc=%h", m_addr);
         end

         if (gnt_ev) begin
            m_out = 1; m_kill = redirect_valid; m_addr = current_pc;
         end else if (m_out) begin
            if (hs) begin m_out = 0; m_kill = 0; end
            else if (redirect_valid) m_kill = 1;
         end
         m_idle = 0;

         // Memory environment follows the DUT's own handshake signals
         if (imem_req && imem_gnt) begin
            mem_busy = 1; mem_addr = current_pc; mem_delay = $urandom_range(0, 2);
         end else if (mem_busy) begin
            if (imem_rvalid && imem_rready) mem_busy = 0;
            else if (mem_delay > 0) mem_delay--;
         end

         // PC register
         pc_upd = !pc_stall;
         pc_val = next_pc;
         @(posedge clk);
         #1;
         if (pc_upd) current_pc = pc_val;
         @(negedge clk);
      end

      check_eq("reset_taken", 32'(reset_done), 32'd1);
      check_eq("loads_seen", 32'(m_loads > 20), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
